// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: state encoding and
// limits for the load-use penalty and its down-counter.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } state_e;

  localparam int unsigned LSC_MIN     = 1;
  localparam int unsigned LSC_MAX     = 15;
  localparam int unsigned STALL_CNT_W = 4;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Request/control bundle between hazard detection, the stall controller and
// the pipeline registers, plus the performance counter readout.
interface pipeline_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             hazard_stall;
  logic             branch_taken;
  logic             mem_busy;
  logic             cnt_clr;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_flush;
  logic             ex_mem_write;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;
  logic [CNT_W-1:0] freeze_cycles;

  modport master (
    output hazard_stall, branch_taken, mem_busy, cnt_clr,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, stall_cycles, flush_events, freeze_cycles
  );

  modport slave (
    input  hazard_stall, branch_taken, mem_busy, cnt_clr,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
           ex_mem_write, stall_cycles, flush_events, freeze_cycles
  );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear that overrides increment.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Turns load-use stall, branch flush and memory-wait requests into per-stage
// write-enable/flush controls, with a multi-cycle load-use penalty.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_stall_ctrl_if.slave bus
);

  if (LOAD_STALL_CYCLES < LSC_MIN || LOAD_STALL_CYCLES > LSC_MAX) begin : g_bad_lsc
    $error("LOAD_STALL_CYCLES must be within 1..15");
  end

  localparam logic [STALL_CNT_W-1:0] RELOAD =
    STALL_CNT_W'((LOAD_STALL_CYCLES > 1) ? (LOAD_STALL_CYCLES - 2) : 0);

  state_e                 state_q, state_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   inc_stall, inc_flush, inc_freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs also depend on rst_n so reset forces the flush pattern at once.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    inc_stall        = 1'b0;
    inc_flush        = 1'b0;
    inc_freeze       = 1'b0;
    bus.pc_write     = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_write  = 1'b1;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_write = 1'b1;

    if (!rst_n) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_write  = 1'b0;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_write = 1'b0;
    end else if (bus.mem_busy) begin
      bus.pc_write     = 1'b0;
      bus.if_id_write  = 1'b0;
      bus.id_ex_write  = 1'b0;
      bus.ex_mem_write = 1'b0;
      inc_freeze       = 1'b1;
    end else if (bus.branch_taken) begin
      bus.if_id_flush = 1'b1;
      bus.id_ex_flush = 1'b1;
      state_d         = RUN;
      cnt_d           = '0;
      inc_flush       = 1'b1;
    end else if (state_q == LOAD_STALL || bus.hazard_stall) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.id_ex_flush = 1'b1;
      inc_stall       = 1'b1;
      if (state_q == RUN) begin
        // The hazard cycle is the first bubble; the counter covers the rest.
        if (LOAD_STALL_CYCLES > 1) begin
          state_d = LOAD_STALL;
          cnt_d   = RELOAD;
        end
      end else if (cnt_q == '0) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.cnt_clr),
    .inc   (inc_stall),
    .count (bus.stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.cnt_clr),
    .inc   (inc_flush),
    .count (bus.flush_events)
  );

  sat_counter #(.W(CNT_W)) u_freeze_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.cnt_clr),
    .inc   (inc_freeze),
    .count (bus.freeze_cycles)
  );

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Consumer of the load-use stall request from hazard_detection. It turns stall, branch-flush and data-memory-wait requests into per-stage write-enable and flush controls for PC, IF/ID, ID/EX and EX/MEM.
- Enforces a configurable multi-cycle load-use penalty.
- Keeps saturating performance counters.
- Sits in the control path between hazard_detection and the pipeline registers.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous, active-low reset
- hazard_stall  in  1  load-use stall request from hazard_detection (combinational, same cycle)
- branch_taken  in  1  taken branch/jump resolved in EX
- mem_busy  in  1  data memory not ready; the whole pipeline must freeze
- cnt_clr  in  1  synchronous clear of all performance counters
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_write  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX clear to bubble (control bits zeroed)
- ex_mem_write  out  1  EX/MEM load enable
- stall_cycles  out  CNT_W  cycles spent in load-use stall
- flush_events  out  CNT_W  number of branch flushes
- freeze_cycles  out  CNT_W  cycles frozen by mem_busy

Behaviour:
- Control outputs are combinational from state and current inputs, so they act in the same cycle as the request. State and counters are registered on the clk rising edge.
- Reset, while rst_n=0:
  - state=RUN, stall counter=0, all performance counters=0.
  - pc_write, if_id_write, id_ex_write and ex_mem_write are 0.
  - if_id_flush and id_ex_flush are 1.
- States: RUN, LOAD_STALL.
- Priority per cycle, highest first:
  1. mem_busy=1, FREEZE:
     - All *_write=0 and both flushes=0.
     - State and stall counter hold.
     - branch_taken and hazard_stall are ignored; they persist because EX/ID are frozen.
     - freeze_cycles increments.
  2. branch_taken=1, FLUSH:
     - pc_write=1, if_id_write=1, if_id_flush=1, id_ex_write=1, id_ex_flush=1, ex_mem_write=1.
     - Next state=RUN and stall counter=0; this aborts any load stall in progress.
     - flush_events increments.
  3. STALL, taken when (state=RUN and hazard_stall=1) or state=LOAD_STALL:
     - pc_write=0, if_id_write=0, if_id_flush=0, id_ex_write=1, id_ex_flush=1, ex_mem_write=1.
     - stall_cycles increments.
  4. Otherwise, NORMAL: all *_write=1 and both flushes=0.
- Stall sequencing:
  - In RUN with a hazard: if LOAD_STALL_CYCLES>1, go to LOAD_STALL and load the counter with LOAD_STALL_CYCLES-2. If LOAD_STALL_CYCLES=1, stay in RUN.
  - In LOAD_STALL: stall regardless of hazard_stall. If counter=0, return to RUN; else decrement.
  - Total bubbles per hazard is exactly LOAD_STALL_CYCLES, not counting freeze cycles.
  - A new hazard_stall seen in RUN immediately after a stall returns starts a new sequence.
- Counters:
  - Width CNT_W, saturate at all-ones with no wrap.
  - cnt_clr=1 clears all three counters at the next edge. If cnt_clr coincides with an increment, the clear wins.
  - State machine and counter behaviour are independent of cnt_clr.
- Reset asserted mid-stall or mid-freeze: immediate return to the reset values above. First cycle after release is RUN/NORMAL.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state encoding (RUN=1'b0, LOAD_STALL=1'b1);
  - localparams for the LOAD_STALL_CYCLES range check and stall-counter width (4 bits).
- One natural sub-module: sat_counter (param W; inputs clk, rst_n, clr, inc; output count). It is instantiated three times.
- Elaboration-time check: 1 <= LOAD_STALL_CYCLES <= 15.

Test Plan:
- Reset, then idle with all inputs 0 -> writes=1, flushes=0, counters=0. Pulsing rst_n low mid-run zeroes counters and forces flushes=1 immediately, asynchronously.
- LOAD_STALL_CYCLES=1, hazard_stall=1 for one cycle -> that cycle pc_write=0, if_id_write=0, id_ex_flush=1. Next cycle NORMAL. stall_cycles=1.
- LOAD_STALL_CYCLES=3, hazard_stall=1 for one cycle only -> exactly 3 consecutive STALL cycles, then NORMAL. stall_cycles=3.
- LOAD_STALL_CYCLES=3, branch_taken=1 on the 2nd stall cycle -> FLUSH that cycle (if_id_flush=1, id_ex_flush=1, pc_write=1), NORMAL next. stall_cycles=1, flush_events=1.
- mem_busy=1 for 4 cycles during the 2nd of 3 stall cycles, with branch_taken=1 held -> all writes=0 and flushes=0 for 4 cycles, freeze_cycles=4. After release, FLUSH wins: stall aborted, flush_events=1.
- CNT_W=4, hazard_stall held 20 cycles -> stall_cycles saturates at 15. cnt_clr=1 together with hazard_stall=1 -> stall_cycles=0 next cycle.
